// File: rtl/adc3664_spi_regfile.sv
// SPI register-file slave: oversampled SCLK/SEN/SDIO, 16-bit R/W+address header, burst auto-increment.
// Outputs registered; cfg_data is a combinational read of the register array.
module adc3664_spi_regfile #(
  parameter int              ADDR_W   = 12,
  parameter int              DATA_W   = 8,
  parameter int              DEPTH    = 4096,
  parameter bit              BURST_EN = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              SCLK,
  input  logic              SEN,
  input  logic              SDIO,
  output logic              SDO,
  output logic              SDO_OE,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              addr_err,
  output logic              frame_done,
  input  logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (DATA_W > 16) ? DATA_W : 16;

  typedef enum logic [2:0] {IDLE, HEADER, WDATA, RDATA, DONE} state_t;

  state_t              state_q;
  logic [2:0]          sclk_q, sen_q;
  logic [1:0]          sdio_q;
  logic                armed_q;
  logic [4:0]          cnt_q;
  logic [SW-1:0]       sh_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   rword_q;
  logic                sdo_q, sdo_oe_q, wr_strobe_q, addr_err_q, frame_done_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Bit 1 of each sync chain is the synchronised level, bit 2 its previous value.
  logic sclk_rise, sclk_fall, sen_rise, sen_fall, sdio_s;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign sen_rise  = sen_q[1] & ~sen_q[2];
  assign sen_fall  = ~sen_q[1] & sen_q[2];
  assign sdio_s    = sdio_q[1];

  logic [15:0]       hdr_w;
  logic [DATA_W-1:0] word_w;
  logic [ADDR_W-1:0] hdr_addr, addr_nxt;
  assign hdr_w    = {sh_q[14:0], sdio_s};
  assign word_w   = {sh_q[DATA_W-2:0], sdio_s};
  assign hdr_addr = hdr_w[ADDR_W-1:0];
  assign addr_nxt = addr_q + ADDR_W'(1);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      sclk_q       <= '0;
      sen_q        <= '0;
      sdio_q       <= '0;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      sh_q         <= '0;
      addr_q       <= '0;
      rword_q      <= '0;
      sdo_q        <= 1'b0;
      sdo_oe_q     <= 1'b0;
      wr_strobe_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
    end else begin
      sclk_q       <= {sclk_q[1:0], SCLK};
      sen_q        <= {sen_q[1:0], SEN};
      sdio_q       <= {sdio_q[0], SDIO};
      wr_strobe_q  <= 1'b0;
      addr_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (sen_q[1]) armed_q <= 1'b1;

      if (sen_rise) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        sdo_q        <= 1'b0;
        sdo_oe_q     <= 1'b0;
        frame_done_q <= (state_q != IDLE);
      end else begin
        case (state_q)
          IDLE: if (sen_fall && armed_q) begin
            state_q <= HEADER;
            cnt_q   <= '0;
          end
          HEADER: if (sclk_rise) begin
            sh_q <= {sh_q[SW-2:0], sdio_s};
            if (cnt_q == 5'd15) begin
              cnt_q  <= '0;
              addr_q <= hdr_addr;
              if (hdr_w[15]) begin
                state_q  <= RDATA;
                rword_q  <= in_range(hdr_addr) ? mem_q[hdr_addr[IW-1:0]] : '0;
                sdo_oe_q <= 1'b1;
              end else begin
                state_q <= WDATA;
              end
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          WDATA: if (sclk_rise) begin
            sh_q <= {sh_q[SW-2:0], sdio_s};
            if (cnt_q == 5'(DATA_W - 1)) begin
              cnt_q <= '0;
              if (in_range(addr_q)) begin
                mem_q[addr_q[IW-1:0]] <= word_w;
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= addr_q;
                wr_data_q   <= word_w;
              end else begin
                addr_err_q <= 1'b1;
              end
              if (BURST_EN) addr_q  <= addr_nxt;
              else          state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          RDATA: begin
            if (sclk_fall) begin
              sdo_q   <= rword_q[DATA_W-1];
              rword_q <= {rword_q[DATA_W-2:0], 1'b0};
            end
            if (sclk_rise) begin
              if (cnt_q == 5'(DATA_W - 1)) begin
                cnt_q <= '0;
                if (!in_range(addr_q)) addr_err_q <= 1'b1;
                if (BURST_EN) begin
                  addr_q  <= addr_nxt;
                  rword_q <= in_range(addr_nxt) ? mem_q[addr_nxt[IW-1:0]] : '0;
                end else begin
                  state_q <= DONE;
                  sdo_q   <= 1'b0;
                end
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SDO        = sdo_q;
  assign SDO_OE     = sdo_oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign addr_err   = addr_err_q;
  assign frame_done = frame_done_q;
  assign cfg_data   = in_range(cfg_addr) ? mem_q[cfg_addr[IW-1:0]] : '0;

endmodule

// File: tb/tb_adc3664_spi_regfile.sv
// Bench: two instances (full-depth burst, and DEPTH=256 single-word) driven by one SPI master,
// checked against an array model of the register file.
module tb_adc3664_spi_regfile;
  logic CLK = 1'b0, Reset_n = 1'b0, SCLK = 1'b0, SEN = 1'b1, SDIO = 1'b0;
  logic [11:0] cfg_addr = '0;
  logic a_sdo, a_oe, a_ws, a_err, a_fd, b_sdo, b_oe, b_ws, b_err, b_fd;
  logic [11:0] a_wa, b_wa;
  logic [7:0]  a_wd, b_wd, a_cfg, b_cfg;

  always #5 CLK = ~CLK;

  adc3664_spi_regfile u_a (
    .CLK(CLK), .Reset_n(Reset_n), .SCLK(SCLK), .SEN(SEN), .SDIO(SDIO),
    .SDO(a_sdo), .SDO_OE(a_oe), .wr_strobe(a_ws), .wr_addr(a_wa), .wr_data(a_wd),
    .addr_err(a_err), .frame_done(a_fd), .cfg_addr(cfg_addr), .cfg_data(a_cfg));

  adc3664_spi_regfile #(.DEPTH(256), .BURST_EN(1'b0)) u_b (
    .CLK(CLK), .Reset_n(Reset_n), .SCLK(SCLK), .SEN(SEN), .SDIO(SDIO),
    .SDO(b_sdo), .SDO_OE(b_oe), .wr_strobe(b_ws), .wr_addr(b_wa), .wr_data(b_wd),
    .addr_err(b_err), .frame_done(b_fd), .cfg_addr(cfg_addr), .cfg_data(b_cfg));

  int npass = 0, ntot = 0;
  logic [7:0] ma [4096];
  logic [7:0] mb [256];
  logic [19:0] a_wq[$], b_wq[$], ea_q[$], eb_q[$];
  int a_errn, b_errn, a_fdn, b_fdn;
  logic [47:0] rx_a, rx_b, oe_a, oe_b;

  always @(negedge CLK) begin
    if (a_ws)  a_wq.push_back({a_wa, a_wd});
    if (b_ws)  b_wq.push_back({b_wa, b_wd});
    if (a_err) a_errn++;
    if (b_err) b_errn++;
    if (a_fd)  a_fdn++;
    if (b_fd)  b_fdn++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    a_wq.delete(); b_wq.delete(); ea_q.delete(); eb_q.delete();
    a_errn = 0; b_errn = 0; a_fdn = 0; b_fdn = 0;
    rx_a = '0; rx_b = '0; oe_a = '0; oe_b = '0;
  endtask

  // One SCLK period: data set while low, SDO sampled just before the rising edge.
  task automatic sclk_bit(input logic b, input int idx);
    SDIO = b;
    #70;
    if (idx >= 16) begin
      rx_a[idx-16] = a_sdo; rx_b[idx-16] = b_sdo;
      oe_a[idx-16] = a_oe;  oe_b[idx-16] = b_oe;
    end
    #10 SCLK = 1'b1;
    #80 SCLK = 1'b0;
  endtask

  task automatic check_queues(input string tag);
    chk({tag, "_a_nstrobe"}, a_wq.size(), ea_q.size());
    chk({tag, "_b_nstrobe"}, b_wq.size(), eb_q.size());
    for (int k = 0; k < a_wq.size() && k < ea_q.size(); k++) chk({tag, "_a_strobe"}, a_wq[k], ea_q[k]);
    for (int k = 0; k < b_wq.size() && k < eb_q.size(); k++) chk({tag, "_b_strobe"}, b_wq[k], eb_q[k]);
  endtask

  // dat holds the data bits after the header, MSB first from bit 47.
  task automatic run_frame(input string tag, input logic [15:0] hdr, input int nbits, input logic [47:0] dat);
    logic [11:0] a0;
    int nw, eerr_b;
    logic [47:0] erx_a, erx_b, eoe;
    logic [7:0] w8;
    clear_mon();
    a0 = hdr[11:0];
    nw = (nbits >= 16) ? (nbits - 16) / 8 : 0;
    erx_a = '0; erx_b = '0; eoe = '0; eerr_b = 0;
    if (hdr[15]) begin
      for (int j = 16; j < nbits; j++) begin
        eoe[j-16] = 1'b1;
        erx_a[j-16] = ma[(a0 + (j-16)/8) % 4096][7 - (j-16)%8];
        if (j < 24 && a0 < 256) erx_b[j-16] = mb[a0][7 - (j-16)%8];
      end
      if (nw >= 1 && a0 >= 256) eerr_b = 1;
    end else begin
      for (int w = 0; w < nw; w++) begin
        w8 = dat[47 - 8*w -: 8];
        ea_q.push_back({12'((a0 + w) % 4096), w8});
        ma[(a0 + w) % 4096] = w8;
        if (w == 0) begin
          if (a0 < 256) begin eb_q.push_back({a0, w8}); mb[a0] = w8; end
          else eerr_b = 1;
        end
      end
    end
    SEN = 1'b0;
    #160;
    for (int i = 0; i < nbits; i++) sclk_bit((i < 16) ? hdr[15-i] : dat[47-(i-16)], i);
    #160 SEN = 1'b1;
    #300;
    check_queues(tag);
    chk({tag, "_a_err"}, a_errn, 0);
    chk({tag, "_b_err"}, b_errn, eerr_b);
    chk({tag, "_a_fdone"}, a_fdn, 1);
    chk({tag, "_b_fdone"}, b_fdn, 1);
    chk({tag, "_a_sdo"}, rx_a, erx_a);
    chk({tag, "_b_sdo"}, rx_b, erx_b);
    chk({tag, "_a_oe"}, oe_a, eoe);
    chk({tag, "_b_oe"}, oe_b, eoe);
    chk({tag, "_oe_idle"}, {a_oe, b_oe, a_sdo, b_sdo}, 4'b0);
  endtask

  task automatic chk_cfg(input logic [11:0] a);
    cfg_addr = a;
    #20;
    chk("cfg_a", a_cfg, ma[a]);
    chk("cfg_b", b_cfg, (a < 256) ? mb[a] : 8'h00);
  endtask

  initial begin
    logic [11:0] pool [12];
    logic [15:0] h;
    int nb;
    pool = '{12'h000, 12'h003, 12'h005, 12'h00F, 12'h0FE, 12'h0FF,
             12'h100, 12'h101, 12'h7FF, 12'hFFD, 12'hFFE, 12'hFFF};
    for (int i = 0; i < 4096; i++) ma[i] = 8'h00;
    for (int i = 0; i < 256; i++)  mb[i] = 8'h00;
    clear_mon();
    #100;
    chk("reset_out_a", {a_sdo, a_oe, a_ws, a_err, a_fd, a_wa, a_wd, a_cfg}, '0);
    chk("reset_out_b", {b_sdo, b_oe, b_ws, b_err, b_fd, b_wa, b_wd, b_cfg}, '0);
    Reset_n = 1'b1;
    #200;

    run_frame("wr5", 16'h0005, 24, {8'hA5, 40'h0});
    chk_cfg(12'h005);
    chk("cfg5_lit", a_cfg, 8'hA5);
    run_frame("rd5", 16'h8005, 24, 48'h0);
    chk("rd5_lit", rx_a[7:0], 8'b10100101);
    run_frame("burst_wrap", 16'h0FFE, 40, {8'h11, 8'h22, 8'h33, 24'h0});
    run_frame("rd_wrap", 16'h8FFF, 32, 48'h0);
    run_frame("wr_oor", 16'h0100, 24, {8'h5A, 40'h0});
    run_frame("rd_oor", 16'h8100, 24, 48'h0);
    run_frame("partial", 16'h0007, 20, {8'hC3, 40'h0});
    chk_cfg(12'h007);
    run_frame("hdr_short", 16'h0009, 10, 48'h0);

    for (int r = 0; r < 14; r++) begin
      h  = {1'($urandom_range(0, 1)), 3'($urandom), pool[$urandom_range(0, 11)]};
      nb = 16 + 8 * $urandom_range(0, 3) + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
      run_frame("rand", h, nb, {$urandom, 16'($urandom)});
    end
    for (int i = 0; i < 12; i++) chk_cfg(pool[i]);

    // Reset in the middle of data bit 4, released with SEN still low.
    clear_mon();
    SEN = 1'b0;
    #160;
    for (int i = 0; i < 20; i++) sclk_bit((i < 16) ? 1'(16'h0005 >> (15 - i)) : 1'b1, i);
    Reset_n = 1'b0;
    for (int i = 0; i < 4096; i++) ma[i] = 8'h00;
    for (int i = 0; i < 256; i++)  mb[i] = 8'h00;
    #40 Reset_n = 1'b1;
    #40;
    for (int i = 0; i < 30; i++) sclk_bit(1'b1, 0);
    chk("rst_outputs", {a_sdo, a_oe, a_ws, a_err, b_sdo, b_oe, b_ws, b_err}, '0);
    #160 SEN = 1'b1;
    #300;
    check_queues("rst_mid");
    chk("rst_errs", a_errn + b_errn, 0);
    chk("rst_fdone", a_fdn + b_fdn, 0);
    chk_cfg(12'h005);
    run_frame("post_rst", 16'h0003, 24, {8'h3C, 40'h0});
    chk_cfg(12'h003);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
